// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - shared opcode encodings and opcode class helpers for the ALU sequencer
package alu_seq_ctrl_pkg;

    // op[3:2] selects the form (00 = SR, 01 = BIO), op[1:0] selects the ALU function
    localparam logic [3:0] OP_INC_SR   = 4'h0;
    localparam logic [3:0] OP_NAND_SR  = 4'h1;
    localparam logic [3:0] OP_SRA_SR   = 4'h2;
    localparam logic [3:0] OP_XOR_SR   = 4'h3;
    localparam logic [3:0] OP_INC_BIO  = 4'h4;
    localparam logic [3:0] OP_NAND_BIO = 4'h5;
    localparam logic [3:0] OP_SRA_BIO  = 4'h6;
    localparam logic [3:0] OP_XOR_BIO  = 4'h7;

    function automatic logic is_sr_op(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

    function automatic logic is_bio_op(input logic [3:0] op);
        return (op[3:2] == 2'b01);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_timer.sv
// rtl/alu_seq_ctrl_timer.sv - BIO ack wait timer (load/count/expire), used only with ALU_SEQ_TIMEOUT_EN
module alu_seq_ctrl_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires in the last allowed wait cycle, so bio_req is held exactly TIMEOUT_CYCLES cycles
    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle ALU sequencer owning SR; optional BIO ack timeout via ALU_SEQ_TIMEOUT_EN
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int DATA_W         = 14,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [DATA_W-1:0] instr_arg,
    output logic [DATA_W-1:0] alu_data0,
    output logic [DATA_W-1:0] alu_data1,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              bio_req,
    output logic              bio_we,
    output logic [DATA_W-1:0] bio_addr,
    output logic [DATA_W-1:0] bio_wdata,
    input  logic [DATA_W-1:0] bio_rdata,
    input  logic              bio_ack,
    output logic [DATA_W-1:0] sr_q,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC_SR  = 3'd1,
        ST_BIO_RD   = 3'd2,
        ST_EXEC_BIO = 3'd3,
        ST_BIO_WR   = 3'd4,
        ST_RETIRE   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_arg;
    logic [DATA_W-1:0] r_operand;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_sr;
    logic              r_err;
    logic              r_rdy;
    logic              w_accept;
    logic              w_tmo;

    // r_rdy keeps instr_ready low while reset is asserted and until the first edge after release
    assign instr_ready = r_rdy && (r_state == ST_IDLE);
    assign w_accept    = instr_valid && instr_ready;
    assign sr_q        = r_sr;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic w_tmr_load;
    logic w_tmr_en;

    assign w_tmr_load = (w_next != r_state);
    assign w_tmr_en   = (r_state == ST_BIO_RD) || (r_state == ST_BIO_WR);

    alu_seq_ctrl_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_tmr_load),
        .i_en      (w_tmr_en),
        .o_expired (w_tmo)
    );
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_arg     <= '0;
            r_operand <= '0;
            r_wdata   <= '0;
            r_sr      <= '0;
            r_err     <= 1'b0;
            r_rdy     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rdy   <= 1'b1;
            if (w_accept) begin
                r_op  <= instr_op;
                r_arg <= instr_arg;
                r_err <= !(is_sr_op(instr_op) || is_bio_op(instr_op));
            end
            if (r_state == ST_EXEC_SR) begin
                r_sr <= alu_result;
            end
            if (r_state == ST_BIO_RD && bio_ack) begin
                r_operand <= bio_rdata;
            end
            if (r_state == ST_EXEC_BIO) begin
                r_wdata <= alu_result;
            end
            if ((r_state == ST_BIO_RD || r_state == ST_BIO_WR) && !bio_ack && w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        alu_data0  = '0;
        alu_data1  = '0;
        alu_opcode = '0;
        bio_req    = 1'b0;
        bio_we     = 1'b0;
        bio_addr   = '0;
        bio_wdata  = '0;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_sr_op(instr_op)) begin
                        w_next = ST_EXEC_SR;
                    end else if (is_bio_op(instr_op)) begin
                        w_next = ST_BIO_RD;
                    end else begin
                        w_next = ST_RETIRE;
                    end
                end
            end
            ST_EXEC_SR: begin
                alu_data0  = r_sr;
                alu_data1  = r_arg;
                alu_opcode = r_op;
                w_next     = ST_RETIRE;
            end
            ST_BIO_RD: begin
                bio_req  = 1'b1;
                bio_addr = r_arg;
                if (bio_ack) begin
                    w_next = ST_EXEC_BIO;
                end else if (w_tmo) begin
                    w_next = ST_RETIRE;
                end
            end
            ST_EXEC_BIO: begin
                alu_data0  = r_operand;
                alu_data1  = r_sr;
                alu_opcode = r_op;
                w_next     = ST_BIO_WR;
            end
            ST_BIO_WR: begin
                bio_req   = 1'b1;
                bio_we    = 1'b1;
                bio_addr  = r_arg;
                bio_wdata = r_wdata;
                if (bio_ack || w_tmo) begin
                    w_next = ST_RETIRE;
                end
            end
            ST_RETIRE: begin
                done   = 1'b1;
                err    = r_err;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl with ALU and BIO responder models
module tb_alu_seq_ctrl;
    localparam int DW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [3:0]    instr_op = 4'h0;
    logic [DW-1:0] instr_arg = '0;
    logic [DW-1:0] alu_data0, alu_data1, alu_result;
    logic [3:0]    alu_opcode;
    logic          bio_req, bio_we;
    logic [DW-1:0] bio_addr, bio_wdata;
    logic [DW-1:0] bio_rdata = '0;
    logic          bio_ack = 1'b0;
    logic [DW-1:0] sr_q;
    logic          done, err;

    int errors = 0;
    int checks = 0;

    // BIO responder controls and records
    int            mem_delay = 1;
    logic          mem_mute = 1'b0;
    logic          wr_block = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    int            wait_cnt = 0;
    int            wr_cnt = 0;
    logic [DW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_addr = '0;

    // Per-instruction observations
    int            lat;
    logic          got_done, got_err;
    int            req_cycles, ready_busy;
    logic [DW-1:0] c1_d0, c1_d1;
    logic [3:0]    c1_opc;
    logic [31:0]   retire_alu;

    alu_seq_ctrl #(.DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_arg(instr_arg),
        .alu_data0(alu_data0), .alu_data1(alu_data1), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .bio_req(bio_req), .bio_we(bio_we), .bio_addr(bio_addr),
        .bio_wdata(bio_wdata), .bio_rdata(bio_rdata), .bio_ack(bio_ack),
        .sr_q(sr_q), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_opcode[1:0])
            2'd0: alu_result = alu_data0 + 1'b1;
            2'd1: alu_result = ~(alu_data0 & alu_data1);
            2'd2: alu_result = (alu_data1 >= DW) ? '0 : (alu_data0 >> alu_data1);
            default: alu_result = alu_data0 ^ alu_data1;
        endcase
    end

    always @(negedge clk) begin
        bio_ack = 1'b0;
        if (bio_req && !mem_mute && !(bio_we && wr_block)) begin
            wait_cnt = wait_cnt + 1;
            if (wait_cnt >= mem_delay) begin
                bio_ack  = 1'b1;
                wait_cnt = 0;
                if (bio_we) begin
                    wr_cnt  = wr_cnt + 1;
                    wr_addr = bio_addr;
                    wr_data = bio_wdata;
                end else begin
                    rd_addr   = bio_addr;
                    bio_rdata = mem_rdata;
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        lat = 0; got_done = 1'b0; got_err = 1'b0; req_cycles = 0; ready_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                c1_d0 = alu_data0; c1_d1 = alu_data1; c1_opc = alu_opcode;
            end
            if (bio_req) req_cycles++;
            if (done) begin
                got_done   = 1'b1;
                got_err    = err;
                retire_alu = {14'(alu_data0 | alu_data1), alu_opcode};
                break;
            end
            if (instr_ready) ready_busy++;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [DW-1:0] arg);
        int n;
        @(negedge clk);
        instr_op = op; instr_arg = arg; instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [DW-1:0] arg,
                          input int exp_lat, input logic exp_err, input logic [DW-1:0] exp_sr);
        issue(op, arg);
        wait_done();
        chk({tag, "_done"}, 32'(got_done), 32'd1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
        chk({tag, "_sr"}, 32'(sr_q), 32'(exp_sr));
    endtask

    initial begin
        int n;
        // reset state
        #12;
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_sr", 32'(sr_q), 32'd0);
        chk("rst_outs", {bio_req, bio_we, done, err, alu_opcode, 14'(alu_data0 | alu_data1)}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_ready_pre", 32'(instr_ready), 32'd0);
        @(posedge clk);
        #1 chk("rel_ready_post", 32'(instr_ready), 32'd1);

        // SR forms
        run_op("inc0", 4'h0, 14'h0123, 2, 1'b0, 14'h0001);
        chk("inc0_c1_d0", 32'(c1_d0), 32'h0000);
        chk("inc0_c1_d1", 32'(c1_d1), 32'h0123);
        chk("inc0_c1_opc", 32'(c1_opc), 32'h0);
        chk("inc0_retire_alu", retire_alu, 32'd0);
        run_op("nand_pre", 4'h1, 14'h0000, 2, 1'b0, 14'h3FFF);
        run_op("inc_wrap", 4'h0, 14'h0000, 2, 1'b0, 14'h0000);
        run_op("nand_pre2", 4'h1, 14'h0000, 2, 1'b0, 14'h3FFF);
        run_op("nand", 4'h1, 14'h00FF, 2, 1'b0, 14'h3F00);
        run_op("xor", 4'h3, 14'h3F00, 2, 1'b0, 14'h0000);
        run_op("nand_pre3", 4'h1, 14'h0000, 2, 1'b0, 14'h3FFF);
        run_op("sra4", 4'h2, 14'd4, 2, 1'b0, 14'h03FF);
        run_op("sra14", 4'h2, 14'd14, 2, 1'b0, 14'h0000);
        run_op("inc_a", 4'h0, 14'h0000, 2, 1'b0, 14'h0001);
        run_op("inc_b", 4'h0, 14'h0000, 2, 1'b0, 14'h0002);

        // BIO form, ack after 3 cycles on both legs
        mem_delay = 3; mem_rdata = 14'h2000;
        run_op("sra_bio", 4'h6, 14'h0010, 8, 1'b0, 14'h0002);
        chk("sra_bio_rdaddr", 32'(rd_addr), 32'h0010);
        chk("sra_bio_wraddr", 32'(wr_addr), 32'h0010);
        chk("sra_bio_wrdata", 32'(wr_data), 32'h0800);
        chk("sra_bio_wrcnt", wr_cnt, 1);

        // BIO form, immediate acks, INC wrap on the operand
        mem_delay = 1; mem_rdata = 14'h3FFF;
        run_op("inc_bio", 4'h4, 14'h0033, 4, 1'b0, 14'h0002);
        chk("inc_bio_wrdata", 32'(wr_data), 32'h0000);
        chk("inc_bio_wrcnt", wr_cnt, 2);

        // illegal opcodes
        run_op("ill_f", 4'hF, 14'h0010, 1, 1'b1, 14'h0002);
        chk("ill_f_noreq", req_cycles, 0);
        run_op("ill_8", 4'h8, 14'h0000, 1, 1'b1, 14'h0002);
        chk("ill_8_noreq", req_cycles, 0);

        // instr_valid held high across a BIO op
        mem_rdata = 14'h0005;
        issue(4'h4, 14'h0020);
        instr_valid = 1'b1; instr_op = 4'h0; instr_arg = '0;
        wait_done();
        chk("hold_done", 32'(got_done), 32'd1);
        chk("hold_ready_busy", ready_busy, 0);
        chk("hold_ready_at_done", 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk("hold_ready_after", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        chk("hold_wrdata", 32'(wr_data), 32'h0006);
        wait_done();
        chk("hold_second_lat", lat, 2);
        chk("hold_second_sr", 32'(sr_q), 32'h0003);

        // reset during BIO_WR wait
        wr_block = 1'b1; mem_rdata = 14'h2000;
        issue(4'h6, 14'h0010);
        n = 0;
        while (!(bio_req && bio_we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached_wr", 32'(bio_req && bio_we), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_req", 32'(bio_req), 32'd0);
        chk("rst_mid_ready", 32'(instr_ready), 32'd0);
        @(posedge clk);
        #1 chk("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; wr_block = 1'b0;
        @(posedge clk);
        #1 chk("rst_mid_ready_after", 32'(instr_ready), 32'd1);
        chk("rst_mid_sr", 32'(sr_q), 32'd0);
        chk("rst_mid_wrcnt", wr_cnt, 3);

`ifdef ALU_SEQ_TIMEOUT_EN
        run_op("nand_tmo_pre", 4'h1, 14'h0000, 2, 1'b0, 14'h3FFF);
        mem_mute = 1'b1;
        run_op("tmo", 4'h4, 14'h0040, 17, 1'b1, 14'h3FFF);
        chk("tmo_req_cycles", req_cycles, 16);
        chk("tmo_wrcnt", wr_cnt, 3);
        mem_mute = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer for the 14-bit ALU. Accepts one instruction at a time over a valid/ready handshake.
- Fetches the operand from the internal SR register or the bus I/O (BIO) port, drives ALU inputs/opcode, and commits the result back to SR or BIO.
- Sits between the instruction decoder and the ALU/BIO bus. Owns the SR register.

Parameters:
- DATA_W, 14, datapath width; matches the ALU.
- TIMEOUT_CYCLES, 16, BIO ack wait limit (used only with ALU_SEQ_TIMEOUT_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  controller can accept (high only in IDLE).
- instr_op  input  4  opcode, encoded by the shared opcode macros.
- instr_arg  input  DATA_W  second operand (SR forms) or BIO address (BIO forms).
- alu_data0  output  DATA_W  ALU operand 0.
- alu_data1  output  DATA_W  ALU operand 1.
- alu_opcode  output  4  ALU opcode.
- alu_result  input  DATA_W  combinational ALU result.
- bio_req  output  1  BIO transaction request.
- bio_we  output  1  1 = write, 0 = read.
- bio_addr  output  DATA_W  BIO address.
- bio_wdata  output  DATA_W  BIO write data.
- bio_rdata  input  DATA_W  BIO read data.
- bio_ack  input  1  BIO completion, 1-cycle pulse.
- sr_q  output  DATA_W  current SR value.
- done  output  1  1-cycle pulse: instruction retired.
- err  output  1  1-cycle pulse with done: illegal opcode or timeout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; sr_q=0; all bus/ALU outputs 0; done=err=0; instr_ready=0 while in reset, 1 from the first clk edge after release.
- Accept: instr_valid && instr_ready at a clk edge latches op/arg. instr_ready drops the next cycle.
- States:
  - IDLE: on accept, SR forms (OP_INC_SR, OP_NAND_SR, OP_SRA_SR, OP_XOR_SR) go to EXEC_SR. BIO forms go to BIO_RD. Any other opcode goes to RETIRE with err.
  - EXEC_SR: alu_data0=sr_q, alu_data1=arg, alu_opcode=op. sr_q<=alu_result at the end of the cycle. Next state RETIRE.
  - BIO_RD: bio_req=1, bio_we=0, bio_addr=arg, held until bio_ack. On ack, latch bio_rdata into the operand register. Next state EXEC_BIO.
  - EXEC_BIO: alu_data0=operand, alu_data1=sr_q, alu_opcode=op. Latch alu_result into the write-data register. Next state BIO_WR.
  - BIO_WR: bio_req=1, bio_we=1, bio_addr=arg, bio_wdata=latched result, held until bio_ack. Next state RETIRE.
  - RETIRE: done=1 for one cycle; err=1 if flagged. Next state IDLE.
- Latency, accept edge to done:
  - SR forms: 2 cycles.
  - BIO forms: 4 cycles plus ack waits.
  - Illegal opcode: 1 cycle.
- ALU operands and opcode are 0 outside the EXEC states.
- bio_ack seen outside BIO_RD/BIO_WR is ignored.
- Arithmetic: width DATA_W, no carry out. INC wraps 0x3FFF→0x0000. SRA operates on unsigned operands, so it is a logical shift; shift ≥DATA_W yields 0.
- instr_valid while busy: ignored; the instruction is not lost, the issuer holds it.
- SR is updated only by SR forms and only in EXEC_SR.
- Reset mid-operation: state returns to IDLE immediately; bio_req drops asynchronously; no done pulse.

Optional Feature:
- ALU_SEQ_TIMEOUT_EN defined:
  - A counter runs in BIO_RD/BIO_WR and clears on state entry.
  - When it reaches TIMEOUT_CYCLES without ack, drop bio_req and go to RETIRE with err=1.
  - SR is unchanged; no BIO write is issued after a read timeout.
- Not defined: waits for ack indefinitely; the counter is not synthesized.

Decomposition:
- Opcode macros come from the shared opcode header (single source for decoder, ALU, sequencer).
- State encodings are localparams in this module.
- One natural sub-module: alu_seq_timer (load/count/expire), instantiated only under ALU_SEQ_TIMEOUT_EN.

Test Plan:
- Reset, then OP_INC_SR with sr=0: done 2 cycles after accept, sr_q=0x0001. Preload 0x3FFF, then OP_INC_SR → sr_q=0x0000.
- sr=0x3FFF, OP_NAND_SR arg=0x00FF → sr_q=0x3F00. Then OP_XOR_SR arg=0x3F00 → sr_q=0x0000.
- sr=0x0002, OP_SRA_BIO addr=0x0010, memory model returns 0x2000 with ack after 3 cycles → write to 0x0010 of 0x0800. done, err=0; sr_q stays 0x0002.
- Undefined opcode → done+err on the cycle after accept; no bio_req; sr_q unchanged.
- instr_valid held high during a BIO op → second instruction accepted only in the cycle after done. rst_n low during BIO_WR wait → bio_req=0 immediately, no done, instr_ready=1 after release.
- ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack → err+done 16 cycles after BIO_RD entry; sr_q unchanged.
